stream_packer: RTL and testbench
================================

# stream_packer

Upstream width-upsizing stage for the dual-bank SPRAM FIFO. It packs RATIO narrow valid/ready beats into one wide word, least-significant lane first, and presents that word on a registered valid/ready output that feeds the FIFO's write port directly. A partial word is flushed on an end-of-packet marker (`in_last`) and, optionally, after an idle timeout.

## Interface
- `IN_WIDTH`, 8: width of one input beat (lane).
- `RATIO`, 4: lanes per output word; must be ≥2.
- `OUT_WIDTH`, `IN_WIDTH*RATIO`: output word width; set this as the FIFO's `DATA_WIDTH`.
- `FLUSH_TIMEOUT`, 16: idle cycles before a partial-word flush; must be ≥2. Used only with the macro.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in IN_WIDTH: input beat.
- `in_valid` in 1: input beat valid.
- `in_last` in 1: beat ends the packet; qualified by `in_valid`.
- `in_ready` out 1: stage accepts a beat this cycle.
- `out_data` out OUT_WIDTH: packed word; lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- `out_keep` out RATIO: per-lane valid mask, always contiguous from lane 0.
- `out_last` out 1: word ends a packet.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts the word.

## Operation
- State:
  - lane counter `cnt` (0..RATIO-1)
  - accumulator `acc` (OUT_WIDTH)
  - output register: `out_data`, `out_keep`, `out_last`, `out_valid`
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready` only and never depends on `in_valid` or `in_last`.
- A beat is accepted when `in_valid && in_ready`. The beat is written into lane `cnt`.
- A beat completes a word when `cnt == RATIO-1 || in_last`. On a completing beat:
  - the output register loads the accumulator merged with the new lane;
  - `out_keep` = ones in lanes 0..cnt;
  - `out_last` = `in_last`;
  - `out_valid` goes to 1;
  - `cnt` and `acc` clear to 0.
- On a non-completing beat, `cnt` increments.
- Unused lanes of a partial word are 0 in `out_data`.
- The output register clears `out_valid` on `out_valid && out_ready`, unless it is reloaded in the same cycle. A reload takes precedence.
- While `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` hold stable.
- `in_last` on the first beat (`cnt == 0`) produces a one-lane word: `out_keep = 1`.
- Reset values:
  - `out_valid`, `out_last`, `out_keep`, `out_data`, `cnt`, `acc`, timer: all 0.
  - `in_ready` is 1 out of reset.
- Reset asserted mid-word discards the partial word and any pending output. No output appears for the discarded data.

## Timing
- Latency: a completing beat accepted at cycle N gives `out_valid` = 1 at cycle N+1.
- Throughput: one input beat per cycle sustained while `out_ready` stays 1. There is no bubble between consecutive words.
- Backpressure: if the output word is held (`out_valid && !out_ready`), `in_ready` is 0 that cycle. When `out_ready` returns, `in_ready` rises in the same cycle.

## Configuration
- Macro `STREAM_PACKER_FLUSH_TIMEOUT_EN`.
- Defined: an idle timer of width $clog2(FLUSH_TIMEOUT+1) is built.
  - It counts cycles with `cnt != 0` and no accepted beat.
  - It clears on an accepted beat or when `cnt == 0`.
  - After FLUSH_TIMEOUT consecutive idle cycles with the output slot free (`!out_valid || out_ready`), the partial word is flushed exactly like a completing beat, but with `out_last` = 0.
  - If the slot is busy, the timer saturates at FLUSH_TIMEOUT and the flush fires on the first free cycle.
  - An accepted beat in the flush cycle has priority: the timer clears and no flush occurs.
- Undefined: no timer logic. A partial word is held indefinitely until it completes or `in_last` arrives.

## Structure
- Package `stream_packer_pkg` holds:
  - helper function `lane_cnt_w(RATIO)` returning $clog2(RATIO);
  - keep-mask helper `keep_mask(cnt)` returning ones in lanes 0..cnt.
- One sub-module `stream_packer_flush_timer` (idle counter plus flush request). It is instantiated only under the macro.

## Test plan
- Full word: IN_WIDTH=8, RATIO=4, beats 0x11, 0x22, 0x33, 0x44, `out_ready`=1 -> one cycle after the 4th beat, `out_data` = 0x44332211, `out_keep` = 4'b1111, `out_last` = 0.
- Partial word: beats 0xAA, then 0xBB with `in_last`=1 -> `out_data` = 0x0000BBAA, `out_keep` = 4'b0011, `out_last` = 1.
- Backpressure: `out_ready`=0 while the first word is valid -> `in_ready`=0 and output stable for 10 cycles. Raise `out_ready` -> the second word completes with no lost or duplicated beats.
- Streaming: 16 back-to-back beats 0x00..0x0F, `out_ready`=1 -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, with `in_ready` never 0.
- Timeout (macro on, FLUSH_TIMEOUT=16): beat 0x5A accepted at cycle A, then idle -> `out_valid` at cycle A+17 with `out_data` = 0x0000005A, `out_keep` = 4'b0001, `out_last` = 0. Macro off: `out_valid` stays 0 for 100 cycles.
- Reset mid-word: 2 beats accepted, then `rst_n` pulsed low -> all outputs 0. Beats 0x01..0x04 afterwards -> exactly one word, 0x04030201.

Source files
------------

// File: rtl/stream_packer_pkg.sv
// +----------------------------------------------------------------------------+
// | stream_packer_pkg : shared sizing and keep-mask helpers for stream_packer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package stream_packer_pkg;

    // Widest lane count the keep-mask helper can describe.
    localparam int MAX_LANES = 64;

    function automatic int lane_cnt_w(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int timer_w(input int flush_timeout);
        return $clog2(flush_timeout + 1);
    endfunction

    // Ones in lanes 0..cnt; a negative cnt yields an empty mask.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int cnt);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            m[k] = (k <= cnt);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_packer_flush_timer.sv
// +----------------------------------------------------------------------------+
// | stream_packer_flush_timer : idle counter that requests a partial flush     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_packer_flush_timer
    import stream_packer_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pending,
    input  logic accept,
    input  logic slot_free,
    output logic flush
);

    localparam int TMR_W = timer_w(FLUSH_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(FLUSH_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(FLUSH_TIMEOUT - 1);

    logic [TMR_W-1:0] timer;
    logic             idle;

    assign idle = pending && !accept;

    // The current idle cycle is the FLUSH_TIMEOUT-th once the timer has
    // counted FLUSH_TIMEOUT-1 earlier ones; a saturated timer waits for a free slot.
    assign flush = idle && slot_free && (timer >= TMR_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!idle || flush) begin
            timer <= '0;
        end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_packer.sv
// +----------------------------------------------------------------------------+
// | stream_packer : packs RATIO narrow beats into one registered wide word.    |
// | Optional idle flush enabled by STREAM_PACKER_FLUSH_TIMEOUT_EN. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_packer #(
    parameter int IN_WIDTH      = 8,
    parameter int RATIO         = 4,
    parameter int OUT_WIDTH     = IN_WIDTH * RATIO,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [RATIO-1:0]     out_keep,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    import stream_packer_pkg::*;

    localparam int CNT_W = lane_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    if (RATIO < 2 || RATIO > MAX_LANES) begin : g_bad_ratio
        $error("stream_packer: RATIO out of range");
    end
    if (OUT_WIDTH != IN_WIDTH * RATIO) begin : g_bad_out_width
        $error("stream_packer: OUT_WIDTH must equal IN_WIDTH*RATIO");
    end
    if (FLUSH_TIMEOUT < 2) begin : g_bad_timeout
        $error("stream_packer: FLUSH_TIMEOUT must be at least 2");
    end

    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] merged;
    logic [RATIO-1:0]     keep_cur;
    logic [RATIO-1:0]     keep_prev;
    logic                 accept;
    logic                 complete;
    logic                 flush;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && ((cnt == LAST_LANE) || in_last);
    assign keep_cur  = RATIO'(keep_mask(int'(cnt)));
    assign keep_prev = RATIO'(keep_mask(int'(cnt) - 1));

    // Lanes above cnt are always zero in acc, so unused lanes of a
    // partial word come out as zero without extra masking.
    always_comb begin
        merged = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
    stream_packer_flush_timer #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .pending   (cnt != '0),
        .accept    (accept),
        .slot_free (in_ready),
        .flush     (flush)
    );
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (complete) begin
            out_data  <= merged;
            out_keep  <= keep_cur;
            out_last  <= in_last;
            out_valid <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
        end else if (flush) begin
            out_data  <= acc;
            out_keep  <= keep_prev;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                acc <= merged;
                cnt <= cnt + 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
// +----------------------------------------------------------------------------+
// | tb_stream_packer : directed and random checks against a lane-queue model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stream_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;
    localparam int FT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;

    always #5 clk = ~clk;

    stream_packer #(
        .IN_WIDTH      (IW),
        .RATIO         (R),
        .OUT_WIDTH     (OW),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: lanes collected so far plus the single output slot.
    logic [IW-1:0] lanes[$];
    bit            m_valid;
    logic [OW-1:0] m_data;
    logic [R-1:0]  m_keep;
    bit            m_last;
    int            idle;

    logic [OW-1:0] got_data[$];
    logic [R-1:0]  got_keep[$];
    logic          got_last[$];
    bit            acc_flag;
    bit            s_valid;

    task automatic check_val(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic void emit(input bit last);
        m_data = '0;
        foreach (lanes[i]) m_data[i*IW +: IW] = lanes[i];
        m_keep  = R'((1 << lanes.size()) - 1);
        m_last  = last;
        m_valid = 1'b1;
        lanes.delete();
    endfunction

    task automatic cycle();
        bit exp_ready;
        bit accept;
        @(negedge clk);
        exp_ready = !m_valid || out_ready;
        check_val("in_ready", in_ready, exp_ready);
        check_val("out_valid", out_valid, m_valid);
        s_valid = out_valid;
        if (m_valid) begin
            check_val("out_data", out_data, m_data);
            check_val("out_keep", out_keep, m_keep);
            check_val("out_last", out_last, m_last);
        end
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_keep.push_back(out_keep);
            got_last.push_back(out_last);
        end
        accept   = in_valid && exp_ready;
        acc_flag = accept;
        if (m_valid && out_ready) m_valid = 1'b0;
        if (accept) begin
            idle = 0;
            lanes.push_back(in_data);
            if (lanes.size() == R || in_last) emit(in_last);
        end else if (lanes.size() != 0) begin
            idle++;
`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
            if (idle >= FT && exp_ready) begin
                emit(1'b0);
                idle = 0;
            end
`endif
        end else begin
            idle = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input bit last, output int ncyc);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        ncyc     = 0;
        acc_flag = 1'b0;
        while (!acc_flag && ncyc < 64) begin
            cycle();
            ncyc++;
        end
        if (!acc_flag) check_val("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_keep", out_keep, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_in_ready", in_ready, 1);
        lanes.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        m_last  = 1'b0;
        idle    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int nc;
        int n0;
        int first;
        logic [OW-1:0] exp_w;

        out_ready = 1'b1;
        #1;
        do_reset();

        // Full word
        send(8'h11, 0, nc); send(8'h22, 0, nc); send(8'h33, 0, nc); send(8'h44, 0, nc);
        check_val("full_valid", out_valid, 1);
        check_val("full_data", out_data, 32'h44332211);
        check_val("full_keep", out_keep, 4'b1111);
        check_val("full_last", out_last, 0);
        idle_cycles(2);

        // Partial word ended by in_last
        send(8'hAA, 0, nc); send(8'hBB, 1, nc);
        check_val("part_valid", out_valid, 1);
        check_val("part_data", out_data, 32'h0000BBAA);
        check_val("part_keep", out_keep, 4'b0011);
        check_val("part_last", out_last, 1);
        idle_cycles(2);

        // Single-beat packet
        send(8'h77, 1, nc);
        check_val("one_keep", out_keep, 4'b0001);
        check_val("one_data", out_data, 32'h00000077);
        idle_cycles(2);

        // Backpressure
        n0 = got_data.size();
        out_ready = 1'b0;
        send(8'h01, 0, nc); send(8'h02, 0, nc); send(8'h03, 0, nc); send(8'h04, 0, nc);
        in_data = 8'h05; in_valid = 1'b1;
        repeat (10) begin
            cycle();
            check_val("bp_accept", acc_flag, 0);
            check_val("bp_hold", out_data, 32'h04030201);
        end
        out_ready = 1'b1;
        send(8'h05, 0, nc);
        check_val("bp_resume_cycles", nc, 1);
        send(8'h06, 0, nc); send(8'h07, 0, nc); send(8'h08, 0, nc);
        idle_cycles(2);
        check_val("bp_count", got_data.size() - n0, 2);
        if (got_data.size() - n0 == 2) begin
            check_val("bp_word0", got_data[n0], 32'h04030201);
            check_val("bp_word1", got_data[n0+1], 32'h08070605);
        end

        // Streaming: back-to-back beats, never stalled
        n0 = got_data.size();
        for (int i = 0; i < 16; i++) begin
            send(IW'(i), 0, nc);
            check_val("stream_cycles", nc, 1);
        end
        idle_cycles(2);
        check_val("stream_count", got_data.size() - n0, 4);
        if (got_data.size() - n0 == 4) begin
            for (int w = 0; w < 4; w++) begin
                for (int b = 0; b < 4; b++) exp_w[b*8 +: 8] = 8'(4*w + b);
                check_val("stream_word", got_data[n0+w], exp_w);
            end
        end

        // Idle timeout
        n0 = got_data.size();
        send(8'h5A, 0, nc);
`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (s_valid) begin
                first = k;
                break;
            end
        end
        check_val("tmo_latency", first, 17);
        check_val("tmo_count", got_data.size() - n0, 1);
        if (got_data.size() - n0 == 1) begin
            check_val("tmo_data", got_data[n0], 32'h0000005A);
            check_val("tmo_keep", got_keep[n0], 4'b0001);
            check_val("tmo_last", got_last[n0], 0);
        end
`else
        first = 0;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            if (s_valid) first++;
        end
        check_val("hold_no_output", first, 0);
        send(8'h5B, 0, nc); send(8'h5C, 0, nc); send(8'h5D, 1, nc);
        idle_cycles(2);
        check_val("hold_count", got_data.size() - n0, 1);
        if (got_data.size() - n0 == 1) begin
            check_val("hold_data", got_data[n0], 32'h5D5C5B5A);
            check_val("hold_last", got_last[n0], 1);
        end
`endif
        idle_cycles(2);

        // Reset mid-word
        send(8'hE1, 0, nc); send(8'hE2, 0, nc);
        do_reset();
        n0 = got_data.size();
        send(8'h01, 0, nc); send(8'h02, 0, nc); send(8'h03, 0, nc); send(8'h04, 0, nc);
        idle_cycles(3);
        check_val("rstmid_count", got_data.size() - n0, 1);
        if (got_data.size() - n0 == 1) begin
            check_val("rstmid_word", got_data[n0], 32'h04030201);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_data   = IW'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 9) < 2);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        out_ready = 1'b1;
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
